uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
UART receive-side frame engine, the counterpart of the transmit control sequencer. It synchronises the serial line and oversamples it at 16x from an internal baud-tick divider. It validates the start bit, shifts in 5–8 data bits LSB-first, checks optional parity and the stop bit, and presents the byte in a single-entry holding register with a valid/read handshake. Frame format is runtime-configured from a 4-bit field, matching the transmit side's configuration encoding.

Parameters:
DIV, 27, Clk cycles per oversample tick (bit period = 16*DIV Clk cycles); must be >=2
SYNC_STAGES, 2, input synchroniser depth on rxd

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous active-high reset
rxd  in  1  serial input; idle high
cfg_load  in  1  load cfg_din[3:0] into the frame configuration
cfg_din  in  8  [1:0] data bits (00=5, 01=6, 10=7, 11=8); [2] parity enable; [3] odd parity; [7:4] ignored
rd  in  1  consumer pops the holding register this cycle
dout  out  8  received byte, zero-extended above the data width
valid  out  1  holding register full
parity_err  out  1  parity error flag for the byte in dout
frame_err  out  1  stop bit sampled low for the byte in dout
overrun  out  1  sticky; a completed frame was lost; cleared by rd
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, release synchronous to Clk): state IDLE; cfg=4'b0011 (8N1); dout=0; valid=0; parity_err=0; frame_err=0; overrun=0; busy=0; synchroniser flops=1; tick divider=0; oversample counter=0.
- Tick: the divider counts 0..DIV-1 and pulses tick for one Clk when it wraps. It free-runs in IDLE. It restarts at 0 when a start edge is detected.
- rxd path: SYNC_STAGES flops, then one history flop for edge detect. Sample value = majority of the synchronised rxd taken at oversample ticks 7, 8 and 9 of each bit.
- cfg_load is accepted only in IDLE with no start edge that cycle; otherwise it is ignored (no queuing). The new configuration applies from the next frame.
- States:
  - IDLE: on falling edge of synchronised rxd -> START; clear oversample count.
  - START: at tick 15, if majority=1 (false start) -> IDLE with no flags; else -> DATA, bit index=0.
  - DATA: at tick 15, shift the majority into shift[7] and right-shift; index++. After N bits -> PARITY if enabled, else STOP. The byte is right-aligned by 8-N at commit.
  - PARITY: at tick 15, store calc_err = (XOR of data bits ^ sampled bit ^ odd) != 0 -> STOP.
  - STOP: at tick 9, once the majority is known, commit and go to IDLE. The line may start the next frame immediately.
- Commit (one Clk):
  - dout <= byte; parity_err <= calc_err (0 if parity off); frame_err <= !stop_majority; valid <= 1.
  - If valid was 1 and rd=0 that cycle: overrun <= 1 and dout/flags are still overwritten with the newer frame.
  - Commit with rd=1 in the same cycle: the new byte is loaded, valid stays 1, no overrun.
- rd with valid=1 and no commit: valid <= 0 and overrun <= 0. dout holds its value. rd with valid=0 has no effect.
- Break (line low for a whole frame): frame_err=1, dout=0. The engine does not re-arm until a rising edge is seen on the line.
- Latency: valid rises 16*DIV*(1+N+P)+10*DIV+~SYNC_STAGES+2 Clk after the start edge.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}
  - uart_cfg_t packed struct {odd, par_en, dbits[1:0]}
  - localparam OVERSAMPLE=16 and sample ticks 7/8/9
  - shared with the transmit side
- Sub-module uart_baud_tick (DIV parameter; inputs restart and enable; output tick) is natural and reusable by the transmitter.

Test Plan:
- 8N1, DIV=4, send 0xA5 -> valid=1, dout=8'hA5, parity_err=0, frame_err=0; rd -> valid=0.
- cfg_din=8'h0E (7 bits, odd parity), send 0x55 with parity bit 1 -> dout=8'h55, parity_err=0; same frame with parity bit 0 -> parity_err=1.
- Glitch: rxd low for 3*DIV Clk then high -> no state beyond START, valid stays 0, busy returns 0.
- Two back-to-back frames 0x11, 0x22 without rd -> dout=8'h22, overrun=1. Third frame with rd coincident with commit -> valid=1, no further overrun.
- Stop bit driven 0 on 0x3C -> dout=8'h3C, frame_err=1. Hold line low for 20 bit times -> exactly one frame commits until rxd rises.
- Rst asserted mid-DATA (asynchronously, between Clk edges) -> outputs at reset values immediately. After release, a clean 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame configuration layout,
// oversampling constants and the 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Same 4-bit layout the transmitter uses: {odd, par_en, dbits[1:0]}.
  // Data width is dbits + 5.
  typedef struct packed {
    logic       odd;
    logic       par_en;
    logic [1:0] dbits;
  } uart_cfg_t;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_A   = 4'd7;
  localparam logic [3:0] SAMPLE_B   = 4'd8;
  localparam logic [3:0] SAMPLE_C   = 4'd9;
  localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

  // 8 data bits, no parity, one stop bit
  localparam uart_cfg_t CFG_RESET = '{odd: 1'b0, par_en: 1'b0, dbits: 2'b11};

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1 and pulses tick_o for one clock
// on the wrap. restart_i forces the count back to 0 so the first tick of a
// frame lands a fixed DIV clocks after the start edge.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: restart wins, otherwise wrap at DIV-1
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Divider count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i && !restart_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame engine. Synchronises rxd, oversamples 16x, votes the
// middle three samples of each bit, and delivers 5..8 data bits with parity
// and stop-bit status into a single-entry holding register.
// Handshake: valid=1 means dout/parity_err/frame_err hold an unread byte;
// rd=1 while valid=1 pops it. A commit in the same cycle as rd replaces the
// byte and keeps valid high; a commit while valid=1 and rd=0 sets overrun.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DIV         = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       rxd,
  input  logic       cfg_load,
  input  logic [7:0] cfg_din,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   sync_chain;
  logic                   hist_q;
  logic                   rxd_s;
  logic                   start_edge;
  logic                   tick;

  rx_state_t  state_q, state_d;
  logic [3:0] os_q, os_d;
  logic [2:0] bit_q, bit_d;
  logic [2:0] samp_q, samp_d;   // [2]=tick 7, [1]=tick 8, [0]=tick 9
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;     // running XOR of data bits
  logic       calc_q, calc_d;   // parity error of the current frame
  uart_cfg_t  cfg_q, cfg_d;

  logic       commit;
  logic       maj_live;
  logic       maj_reg;
  logic [2:0] last_idx;
  logic [7:0] rx_byte;

  logic [7:0] dout_q;
  logic       valid_q, perr_q, ferr_q, ovr_q;
  logic       unused_cfg_hi;

  assign unused_cfg_hi = ^cfg_din[7:4];
  assign sync_chain    = {sync_q, rxd};
  assign rxd_s         = sync_q[SYNC_STAGES-1];

  // Input synchroniser chain plus one history flop for start-edge detection
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_chain[SYNC_STAGES-1:0];
      hist_q <= rxd_s;
    end
  end

  // Only a high-to-low transition starts a frame, so a line held low
  // (break) cannot re-arm until it has gone high again.
  assign start_edge = (state_q == IDLE) && hist_q && !rxd_s;
  // At tick 9 the third sample is still on the wire, so vote it live.
  assign maj_live   = maj3(samp_q[2], samp_q[1], rxd_s);
  assign maj_reg    = maj3(samp_q[2], samp_q[1], samp_q[0]);
  assign last_idx   = 3'd4 + {1'b0, cfg_q.dbits};
  // N bits arrive at shift[7:8-N]; right-align them, zero above.
  assign rx_byte    = shift_q >> (2'd3 - cfg_q.dbits);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .restart_i (start_edge),
    .enable_i  (1'b1),
    .tick_o    (tick)
  );

  // Frame FSM next-state: sampling, shifting, parity check and commit
  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    samp_d  = samp_q;
    shift_d = shift_q;
    par_d   = par_q;
    calc_d  = calc_q;
    cfg_d   = cfg_q;
    commit  = 1'b0;

    if (state_q == IDLE) begin
      if (start_edge) begin
        state_d = START;
        os_d    = '0;
      end else if (cfg_load) begin
        cfg_d = uart_cfg_t'(cfg_din[3:0]);
      end
    end else if (tick) begin
      os_d = os_q + 4'd1;
      if (os_q == SAMPLE_A) samp_d[2] = rxd_s;
      if (os_q == SAMPLE_B) samp_d[1] = rxd_s;
      if (os_q == SAMPLE_C) samp_d[0] = rxd_s;

      case (state_q)
        START: begin
          if (os_q == LAST_TICK) begin
            if (maj_reg) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              bit_d   = '0;
              shift_d = '0;
              par_d   = 1'b0;
              calc_d  = 1'b0;
            end
          end
        end
        DATA: begin
          if (os_q == LAST_TICK) begin
            shift_d = {maj_reg, shift_q[7:1]};
            par_d   = par_q ^ maj_reg;
            bit_d   = bit_q + 3'd1;
            if (bit_q == last_idx) begin
              state_d = cfg_q.par_en ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (os_q == LAST_TICK) begin
            calc_d  = par_q ^ maj_reg ^ cfg_q.odd;
            state_d = STOP;
          end
        end
        STOP: begin
          if (os_q == SAMPLE_C) begin
            commit  = 1'b1;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame FSM and datapath registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      samp_q  <= '1;
      shift_q <= '0;
      par_q   <= 1'b0;
      calc_q  <= 1'b0;
      cfg_q   <= CFG_RESET;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      calc_q  <= calc_d;
      cfg_q   <= cfg_d;
    end
  end

  // Holding register: commit loads a new byte, rd pops and clears overrun
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (commit) begin
      dout_q  <= rx_byte;
      perr_q  <= cfg_q.par_en & calc_q;
      ferr_q  <= !maj_live;
      valid_q <= 1'b1;
      if (valid_q) begin
        ovr_q <= !rd;
      end
    end else if (rd && valid_q) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign dout       = dout_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed vector table, hand-written corner
// sequences and a randomized run against a frame-level reference model.
module tb_uart_rx_frame;

  localparam int DIV         = 4;
  localparam int SYNC_STAGES = 2;
  localparam int BIT         = 16 * DIV;
  localparam int W           = 10;   // {parity_err, frame_err, byte}

  logic       Clk = 1'b0;
  logic       Rst;
  logic       rxd;
  logic       cfg_load;
  logic [7:0] cfg_din;
  logic       rd;
  logic [7:0] dout;
  logic       valid, parity_err, frame_err, overrun, busy;

  int n_total = 0;
  int n_pass  = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ovr;

  typedef struct {
    logic [7:0] cfg;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[9];

  uart_rx_frame #(.DIV(DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .rxd        (rxd),
    .cfg_load   (cfg_load),
    .cfg_din    (cfg_din),
    .rd         (rd),
    .dout       (dout),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic load_cfg(input logic [7:0] c);
    @(negedge Clk);
    cfg_din  = c;
    cfg_load = 1'b1;
    @(negedge Clk);
    cfg_load = 1'b0;
  endtask

  task automatic pop();
    @(negedge Clk);
    rd = 1'b1;
    @(negedge Clk);
    rd = 1'b0;
  endtask

  // Drives one frame; bit count and parity presence come from cfg.
  task automatic send_frame(input logic [7:0] cfg, input logic [7:0] data,
                            input logic par_val, input logic stop_val, input int gap);
    int nb;
    nb = int'(cfg[1:0]) + 5;
    @(negedge Clk);
    rxd = 1'b0;
    repeat (BIT) @(negedge Clk);
    for (int i = 0; i < nb; i++) begin
      rxd = data[i];
      repeat (BIT) @(negedge Clk);
    end
    if (cfg[2]) begin
      rxd = par_val;
      repeat (BIT) @(negedge Clk);
    end
    rxd = stop_val;
    repeat (BIT) @(negedge Clk);
    rxd = 1'b1;
    repeat (gap) @(negedge Clk);
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: keep the low N bits, parity error when the count of
  // ones over data plus parity bit does not have the configured oddness.
  function automatic logic [W-1:0] model_frame(input logic [7:0] cfg, input logic [7:0] data,
                                               input logic par_val, input logic stop_val);
    int         nb;
    int         ones;
    logic [7:0] b;
    logic       perr;
    nb   = int'(cfg[1:0]) + 5;
    b    = data & 8'((1 << nb) - 1);
    ones = $countones(b) + int'(par_val);
    perr = cfg[2] && ((ones % 2) != int'(cfg[3]));
    return {perr, ~stop_val, b};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] c, d;
    logic       p, s;

    vecs[0] = '{8'h03, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h0E, 8'h55, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[2] = '{8'h0E, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0};
    vecs[3] = '{8'h03, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'hFF, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0};
    vecs[5] = '{8'h05, 8'h2B, 1'b0, 1'b1, 8'h2B, 1'b0, 1'b0};
    vecs[6] = '{8'h06, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0};
    vecs[7] = '{8'hF9, 8'hC6, 1'b1, 1'b1, 8'h06, 1'b0, 1'b0};
    vecs[8] = '{8'h0F, 8'h96, 1'b0, 1'b1, 8'h96, 1'b1, 1'b0};

    Rst = 1'b1; rxd = 1'b1; cfg_load = 1'b0; cfg_din = 8'h00; rd = 1'b0;
    exp_ovr = 1'b0;
    idle(3);
    check("rst_valid", valid, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_flags", {parity_err, frame_err}, 2'b00);
    Rst = 1'b0;
    idle(4);
    check("post_rst_valid", valid, 1'b0);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      load_cfg(vecs[i].cfg);
      send_frame(vecs[i].cfg, vecs[i].data, vecs[i].par, vecs[i].stop, 4);
      check($sformatf("vec%0d_valid", i), valid, 1'b1);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_perr", i), parity_err, vecs[i].exp_perr);
      check($sformatf("vec%0d_ferr", i), frame_err, vecs[i].exp_ferr);
      check($sformatf("vec%0d_overrun", i), overrun, 1'b0);
      check($sformatf("vec%0d_busy", i), busy, 1'b0);
      pop();
      check($sformatf("vec%0d_valid_after_rd", i), valid, 1'b0);
      check($sformatf("vec%0d_dout_hold", i), dout, vecs[i].exp_dout);
    end

    // Glitch shorter than half a bit: false start, back to idle
    load_cfg(8'h03);
    @(negedge Clk);
    rxd = 1'b0;
    idle(3 * DIV);
    rxd = 1'b1;
    idle(10);
    check("glitch_busy_in_start", busy, 1'b1);
    idle(90);
    check("glitch_busy_cleared", busy, 1'b0);
    check("glitch_valid", valid, 1'b0);

    // Back-to-back frames without rd, then rd coincident with commit
    send_frame(8'h03, 8'h11, 1'b0, 1'b1, 4);
    send_frame(8'h03, 8'h22, 1'b0, 1'b1, 4);
    check("b2b_valid", valid, 1'b1);
    check("b2b_dout", dout, 8'h22);
    check("b2b_overrun", overrun, 1'b1);
    fork
      send_frame(8'h03, 8'h33, 1'b0, 1'b1, 4);
      begin
        // commit edge is 618.5 clocks after the start bit is driven
        repeat (619) @(negedge Clk);
        rd = 1'b1;
        @(negedge Clk);
        rd = 1'b0;
        check("coinc_valid", valid, 1'b1);
        check("coinc_dout", dout, 8'h33);
        check("coinc_overrun", overrun, 1'b0);
      end
    join
    pop();
    check("coinc_popped", valid, 1'b0);

    // Break: line low for 20 bit times commits exactly one frame
    @(negedge Clk);
    rxd = 1'b0;
    idle(11 * BIT);
    check("break_valid", valid, 1'b1);
    check("break_dout", dout, 8'h00);
    check("break_ferr", frame_err, 1'b1);
    check("break_busy", busy, 1'b0);
    pop();
    check("break_popped", valid, 1'b0);
    idle(9 * BIT - 2);
    check("break_no_rearm_valid", valid, 1'b0);
    check("break_no_rearm_busy", busy, 1'b0);
    rxd = 1'b1;
    idle(BIT);
    check("break_release_valid", valid, 1'b0);
    check("break_release_busy", busy, 1'b0);

    // Randomized frames against the reference model
    exp_q.delete();
    exp_ovr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      c = 8'($urandom);
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 4) != 0);
      load_cfg(c);
      send_frame(c, d, p, s, 4);
      if (exp_q.size() != 0) begin
        exp_q.delete(0);
        exp_ovr = 1'b1;
      end
      exp_q.push_back(model_frame(c, d, p, s));
      check("rnd_valid", valid, 1'b1);
      if ($urandom_range(0, 3) != 0 || i == 19) begin
        check($sformatf("rnd%0d_dout", i), dout, exp_q[0][7:0]);
        check($sformatf("rnd%0d_ferr", i), frame_err, exp_q[0][8]);
        check($sformatf("rnd%0d_perr", i), parity_err, exp_q[0][9]);
        check($sformatf("rnd%0d_overrun", i), overrun, exp_ovr);
        pop();
        check($sformatf("rnd%0d_valid_after_rd", i), valid, 1'b0);
        check($sformatf("rnd%0d_overrun_after_rd", i), overrun, 1'b0);
        exp_q.delete(0);
        exp_ovr = 1'b0;
      end
    end

    // Asynchronous reset in the middle of a data bit
    load_cfg(8'h04);
    send_frame(8'h04, 8'h17, 1'b0, 1'b1, 4);
    check("pre_rst_valid", valid, 1'b1);
    check("pre_rst_dout", dout, 8'h17);
    @(negedge Clk);
    rxd = 1'b0;
    idle(BIT);
    rxd = 1'b1;
    idle(40);
    check("mid_data_busy", busy, 1'b1);
    #2;
    Rst = 1'b1;
    #1;
    check("async_rst_valid", valid, 1'b0);
    check("async_rst_dout", dout, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_flags", {overrun, parity_err, frame_err}, 3'b000);
    @(negedge Clk);
    idle(3);
    Rst = 1'b0;
    idle(BIT);
    // configuration returned to 8N1 by reset
    send_frame(8'h03, 8'h81, 1'b0, 1'b1, 4);
    check("after_rst_valid", valid, 1'b1);
    check("after_rst_dout", dout, 8'h81);
    check("after_rst_flags", {parity_err, frame_err}, 2'b00);
    pop();
    check("after_rst_popped", valid, 1'b0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
